mannix_job_sched: RTL and testbench

Parametrised job scheduler sitting between the software register file and the Mannix compute engines (FC, activation, pool, CNN, and future engines). It replaces per-engine GO/DONE wiring with a single job queue. Software pushes descriptors tagged with a target engine. The scheduler issues them in order, tracks per-engine busy state, and enforces optional barriers so that dependent layers never start before their producers finish.

---
 rtl/mannix_sched_pkg.sv | 21 ++
 rtl/mannix_sched_fifo.sv | 66 ++++++
 rtl/mannix_job_sched.sv | 158 +++++++++++++++
 tb/tb_mannix_job_sched.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mannix_sched_pkg.sv
// Shared types for the Mannix job scheduler: FSM state encoding and the
// queued job record. Widths match the scheduler's default parameters.
package mannix_sched_pkg;

  localparam int unsigned SCHED_NUM_ENG    = 4;
  localparam int unsigned SCHED_DESC_WIDTH = 128;
  localparam int unsigned SCHED_ENG_ID_W   = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    BARRIER = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [SCHED_ENG_ID_W-1:0]   eng;
    logic                        barrier;
    logic [SCHED_DESC_WIDTH-1:0] desc;
  } sched_job_t;

endpackage

// File: rtl/mannix_sched_fifo.sv
// Synchronous job FIFO with occupancy count. A push is taken only when not
// full and a pop only when not empty, so both may happen in one cycle.
module mannix_sched_fifo
  import mannix_sched_pkg::*;
#(
  parameter type         T     = sched_job_t,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  T                 data_i,
  input  logic             pop_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Occupancy next-state from the accepted push/pop pair.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointer and count registers; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; the count alone decides which entries are meaningful.
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/mannix_job_sched.sv
// Mannix job scheduler: in-order job queue feeding NUM_ENG compute engines,
// with per-engine busy tracking, optional all-idle barriers, a completed-job
// counter and sticky error flags.
module mannix_job_sched
  import mannix_sched_pkg::*;
#(
  parameter int unsigned NUM_ENG     = 4,
  parameter int unsigned DESC_WIDTH  = 128,
  parameter int unsigned QUEUE_DEPTH = 8,
  parameter int unsigned ENG_ID_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sw_job_valid,
  output logic                  sw_job_ready,
  input  logic [ENG_ID_W-1:0]   sw_job_eng,
  input  logic                  sw_job_barrier,
  input  logic [DESC_WIDTH-1:0] sw_job_desc,
  output logic [NUM_ENG-1:0]    eng_go,
  output logic [DESC_WIDTH-1:0] eng_desc,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic [NUM_ENG-1:0]    eng_busy,
  output logic                  sched_idle,
  output logic [CNT_W-1:0]      jobs_done_cnt,
  output logic                  err_bad_eng,
  output logic                  err_spurious_done
);

  localparam int unsigned QCNT_W = $clog2(QUEUE_DEPTH) + 1;

  // Job record sized by this instance's parameters.
  typedef struct packed {
    logic [ENG_ID_W-1:0]   eng;
    logic                  barrier;
    logic [DESC_WIDTH-1:0] desc;
  } job_t;

  sched_state_e          state_q, state_d;
  logic [NUM_ENG-1:0]    busy_q, go_q;
  logic [DESC_WIDTH-1:0] desc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_bad_q, err_spur_q;

  job_t                  push_job, head;
  logic [QCNT_W-1:0]     fifo_count;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, issue, bad_set;
  logic                  head_bad, target_busy, more_after_pop;
  logic [NUM_ENG-1:0]    head_onehot, done_ok;
  logic [CNT_W-1:0]      done_inc;

  assign sw_job_ready = !fifo_full;
  assign push         = sw_job_valid && sw_job_ready;

  assign push_job.eng     = sw_job_eng;
  assign push_job.barrier = sw_job_barrier;
  assign push_job.desc    = sw_job_desc;

  mannix_sched_fifo #(
    .T     (job_t),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_job),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Decode the head job's target and count this cycle's legitimate completions.
  always_comb begin
    head_onehot = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      head_onehot[i] = (head.eng == ENG_ID_W'(i));
    end
    head_bad       = (32'(head.eng) >= NUM_ENG);
    target_busy    = |(busy_q & head_onehot);
    more_after_pop = (fifo_count > QCNT_W'(1)) || push;
    done_ok        = eng_done & busy_q;
    done_inc       = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      done_inc = done_inc + CNT_W'(done_ok[i]);
    end
  end

  // Dispatch FSM next-state and issue/pop decisions.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    issue   = 1'b0;
    bad_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A push this cycle makes the head visible next cycle, so CHECK is ready for it.
        if (!fifo_empty || push) state_d = CHECK;
      end
      CHECK: begin
        if (fifo_empty) begin
          state_d = IDLE;
        end else if (head_bad) begin
          pop     = 1'b1;
          bad_set = 1'b1;
          state_d = more_after_pop ? CHECK : IDLE;
        end else if (head.barrier && (busy_q != '0)) begin
          state_d = BARRIER;
        end else if (!target_busy) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_d = more_after_pop ? CHECK : IDLE;
        end
      end
      BARRIER: begin
        // All engines idle means the held barrier job's target is idle too; issue now.
        if (busy_q == '0) begin
          pop     = 1'b1;
          issue   = 1'b1;
          state_d = more_after_pop ? CHECK : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, busy vector, issue outputs, completion counter and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= '0;
      go_q       <= '0;
      desc_q     <= '0;
      cnt_q      <= '0;
      err_bad_q  <= 1'b0;
      err_spur_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (busy_q & ~done_ok) | (issue ? head_onehot : '0);
      go_q       <= issue ? head_onehot : '0;
      if (issue) desc_q <= head.desc;
      cnt_q      <= cnt_q + done_inc;
      err_bad_q  <= err_bad_q | bad_set;
      err_spur_q <= err_spur_q | (|(eng_done & ~busy_q));
    end
  end

  assign eng_go            = go_q;
  assign eng_desc          = desc_q;
  assign eng_busy          = busy_q;
  assign jobs_done_cnt     = cnt_q;
  assign err_bad_eng       = err_bad_q;
  assign err_spurious_done = err_spur_q;
  assign sched_idle        = fifo_empty && (busy_q == '0);

endmodule

// File: tb/tb_mannix_job_sched.sv
// Directed bench for mannix_job_sched. Cycle 0 of each scenario is the first
// cycle after reset release; inputs and samples both sit 1ns after posedge.
module tb_mannix_job_sched;

  localparam int NE = 4;
  localparam int DW = 128;
  localparam int EW = 3;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sw_job_valid;
  logic          sw_job_ready;
  logic [EW-1:0] sw_job_eng;
  logic          sw_job_barrier;
  logic [DW-1:0] sw_job_desc;
  logic [NE-1:0] eng_go;
  logic [DW-1:0] eng_desc;
  logic [NE-1:0] eng_done;
  logic [NE-1:0] eng_busy;
  logic          sched_idle;
  logic [CW-1:0] jobs_done_cnt;
  logic          err_bad_eng;
  logic          err_spurious_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mannix_job_sched #(
    .NUM_ENG     (NE),
    .DESC_WIDTH  (DW),
    .QUEUE_DEPTH (8),
    .ENG_ID_W    (EW),
    .CNT_W       (CW)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .sw_job_valid      (sw_job_valid),
    .sw_job_ready      (sw_job_ready),
    .sw_job_eng        (sw_job_eng),
    .sw_job_barrier    (sw_job_barrier),
    .sw_job_desc       (sw_job_desc),
    .eng_go            (eng_go),
    .eng_desc          (eng_desc),
    .eng_done          (eng_done),
    .eng_busy          (eng_busy),
    .sched_idle        (sched_idle),
    .jobs_done_cnt     (jobs_done_cnt),
    .err_bad_eng       (err_bad_eng),
    .err_spurious_done (err_spurious_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_job(input logic v, input int eng, input logic bar, input int desc);
    sw_job_valid   = v;
    sw_job_eng     = EW'(eng);
    sw_job_barrier = bar;
    sw_job_desc    = DW'(desc);
  endtask

  task automatic do_reset();
    drive_job(1'b0, 0, 1'b0, 0);
    eng_done = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL reset_go: got %b exp 0000", eng_go); end
    checks++; if (eng_busy !== 4'b0000) begin failures++; $display("FAIL reset_busy: got %b exp 0000", eng_busy); end
    checks++; if (jobs_done_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt: got %0d exp 0", jobs_done_cnt); end
    checks++; if (eng_desc !== 128'd0) begin failures++; $display("FAIL reset_desc: got %h exp 0", eng_desc); end
    checks++; if ({sw_job_ready, sched_idle, err_bad_eng, err_spurious_done} !== 4'b1100) begin
      failures++; $display("FAIL reset_flags: ready/idle/bad/spur got %b exp 1100",
                           {sw_job_ready, sched_idle, err_bad_eng, err_spurious_done});
    end
  endtask

  task automatic test_single();
    do_reset();
    drive_job(1'b1, 2, 1'b0, 'hA5);           // cycle 0
    tick();
    drive_job(1'b0, 0, 1'b0, 0);              // cycle 1
    checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL single_early_go: got %b exp 0000", eng_go); end
    tick();                                   // cycle 2
    checks++; if (eng_go !== 4'b0100) begin failures++; $display("FAIL single_go: got %b exp 0100", eng_go); end
    checks++; if (eng_desc !== 128'hA5) begin failures++; $display("FAIL single_desc: got %h exp a5", eng_desc); end
    checks++; if (eng_busy !== 4'b0100) begin failures++; $display("FAIL single_busy: got %b exp 0100", eng_busy); end
    tick();                                   // cycle 3
    checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL single_go_pulse: got %b exp 0000", eng_go); end
    repeat (7) tick();                        // cycle 10
    eng_done = 4'b0100;
    tick();                                   // cycle 11
    eng_done = '0;
    checks++; if (eng_busy !== 4'b0000) begin failures++; $display("FAIL single_busy_clr: got %b exp 0000", eng_busy); end
    checks++; if (jobs_done_cnt !== 16'd1) begin failures++; $display("FAIL single_cnt: got %0d exp 1", jobs_done_cnt); end
    checks++; if (sched_idle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b exp 1", sched_idle); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_job(1'b1, 0, 1'b0, 'h10);           // cycle 0
    tick();
    drive_job(1'b1, 1, 1'b0, 'h11);           // cycle 1
    tick();                                   // cycle 2
    checks++; if (eng_go !== 4'b0001 || eng_desc !== 128'h10) begin
      failures++; $display("FAIL b2b_go0: go %b desc %h exp 0001 10", eng_go, eng_desc); end
    drive_job(1'b1, 3, 1'b0, 'h13);
    tick();                                   // cycle 3
    checks++; if (eng_go !== 4'b0010 || eng_desc !== 128'h11) begin
      failures++; $display("FAIL b2b_go1: go %b desc %h exp 0010 11", eng_go, eng_desc); end
    drive_job(1'b1, 0, 1'b0, 'h20);
    tick();                                   // cycle 4
    drive_job(1'b0, 0, 1'b0, 0);
    checks++; if (eng_go !== 4'b1000 || eng_desc !== 128'h13) begin
      failures++; $display("FAIL b2b_go3: go %b desc %h exp 1000 13", eng_go, eng_desc); end
    tick();                                   // cycle 5: second eng0 job stalls
    checks++; if (eng_go !== 4'b0000 || eng_busy !== 4'b1011) begin
      failures++; $display("FAIL b2b_stall: go %b busy %b exp 0000 1011", eng_go, eng_busy); end
    tick();                                   // cycle 6
    eng_done = 4'b0001;
    tick();                                   // cycle 7
    eng_done = '0;
    checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL b2b_no_bypass: got %b exp 0000", eng_go); end
    tick();                                   // cycle 8
    checks++; if (eng_go !== 4'b0001 || eng_desc !== 128'h20) begin
      failures++; $display("FAIL b2b_reissue: go %b desc %h exp 0001 20", eng_go, eng_desc); end
    eng_done = 4'b1011;                       // three simultaneous completions
    tick();
    eng_done = '0;
    checks++; if (jobs_done_cnt !== 16'd4 || sched_idle !== 1'b1 || err_spurious_done !== 1'b0) begin
      failures++; $display("FAIL b2b_multi_done: cnt %0d idle %b spur %b exp 4 1 0",
                           jobs_done_cnt, sched_idle, err_spurious_done); end
  endtask

  task automatic test_barrier();
    do_reset();
    drive_job(1'b1, 3, 1'b0, 'h30);           // cycle 0
    tick();
    drive_job(1'b0, 0, 1'b0, 0);              // cycle 1
    tick();                                   // cycle 2
    checks++; if (eng_go !== 4'b1000) begin failures++; $display("FAIL bar_go3: got %b exp 1000", eng_go); end
    drive_job(1'b1, 1, 1'b1, 'h31);           // barrier job
    tick();                                   // cycle 3
    drive_job(1'b1, 2, 1'b0, 'h32);           // plain job behind it
    tick();                                   // cycle 4
    drive_job(1'b0, 0, 1'b0, 0);
    for (int c = 4; c < 8; c++) begin
      checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL bar_hold_c%0d: got %b exp 0000", c, eng_go); end
      tick();
    end
    eng_done = 4'b1000;                       // cycle 8
    tick();                                   // cycle 9
    eng_done = '0;
    checks++; if (eng_go !== 4'b0000) begin failures++; $display("FAIL bar_early: got %b exp 0000", eng_go); end
    tick();                                   // cycle 10
    checks++; if (eng_go !== 4'b0010 || eng_desc !== 128'h31) begin
      failures++; $display("FAIL bar_release: go %b desc %h exp 0010 31", eng_go, eng_desc); end
    tick();                                   // cycle 11
    checks++; if (eng_go !== 4'b0100 || eng_desc !== 128'h32) begin
      failures++; $display("FAIL bar_follow: go %b desc %h exp 0100 32", eng_go, eng_desc); end
    eng_done = 4'b0110;
    tick();
    eng_done = '0;
    checks++; if (jobs_done_cnt !== 16'd3 || sched_idle !== 1'b1) begin
      failures++; $display("FAIL bar_end: cnt %0d idle %b exp 3 1", jobs_done_cnt, sched_idle); end
  endtask

  task automatic test_full();
    do_reset();
    drive_job(1'b1, 0, 1'b0, 'h40);           // cycle 0
    tick();
    drive_job(1'b0, 0, 1'b0, 0);
    tick();                                   // cycle 2: eng0 busy
    checks++; if (eng_go !== 4'b0001) begin failures++; $display("FAIL full_first_go: got %b exp 0001", eng_go); end
    for (int k = 0; k < 8; k++) begin         // cycles 2..9
      checks++; if (sw_job_ready !== 1'b1) begin failures++; $display("FAIL full_ready_%0d: got %b exp 1", k, sw_job_ready); end
      drive_job(1'b1, 0, 1'b0, 'h50 + k);
      tick();
    end
    drive_job(1'b1, 0, 1'b0, 'h58);           // cycle 10: ninth push, refused
    checks++; if (sw_job_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low: got %b exp 0", sw_job_ready); end
    tick();                                   // cycle 11
    drive_job(1'b0, 0, 1'b0, 0);
    eng_done = 4'b0001;
    tick();                                   // cycle 12
    eng_done = '0;
    checks++; if (sw_job_ready !== 1'b0 || eng_go !== 4'b0000) begin
      failures++; $display("FAIL full_pre_pop: ready %b go %b exp 0 0000", sw_job_ready, eng_go); end
    tick();                                   // cycle 13
    checks++; if (sw_job_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back: got %b exp 1", sw_job_ready); end
    checks++; if (eng_go !== 4'b0001 || eng_desc !== 128'h50) begin
      failures++; $display("FAIL full_drain_0: go %b desc %h exp 0001 50", eng_go, eng_desc); end
    for (int k = 1; k < 8; k++) begin
      eng_done = 4'b0001;
      tick();
      eng_done = '0;
      tick();
      checks++; if (eng_go !== 4'b0001 || eng_desc !== DW'('h50 + k)) begin
        failures++; $display("FAIL full_drain_%0d: go %b desc %h exp 0001 %h", k, eng_go, eng_desc, 'h50 + k); end
    end
    eng_done = 4'b0001;
    tick();
    eng_done = '0;
    tick();
    tick();
    checks++; if (eng_go !== 4'b0000 || sched_idle !== 1'b1 || jobs_done_cnt !== 16'd9) begin
      failures++; $display("FAIL full_end: go %b idle %b cnt %0d exp 0000 1 9", eng_go, sched_idle, jobs_done_cnt); end
  endtask

  task automatic test_errors();
    do_reset();
    drive_job(1'b1, 5, 1'b0, 'h60);           // cycle 0: engine 5 does not exist
    tick();
    drive_job(1'b1, 1, 1'b0, 'h61);           // cycle 1
    tick();                                   // cycle 2
    drive_job(1'b0, 0, 1'b0, 0);
    checks++; if (err_bad_eng !== 1'b1 || eng_go !== 4'b0000) begin
      failures++; $display("FAIL err_bad: bad %b go %b exp 1 0000", err_bad_eng, eng_go); end
    tick();                                   // cycle 3
    checks++; if (eng_go !== 4'b0010 || eng_desc !== 128'h61 || err_spurious_done !== 1'b0) begin
      failures++; $display("FAIL err_next_job: go %b desc %h spur %b exp 0010 61 0", eng_go, eng_desc, err_spurious_done); end
    eng_done = 4'b0100;                       // engine 2 is idle
    tick();
    eng_done = '0;
    checks++; if (err_spurious_done !== 1'b1 || jobs_done_cnt !== 16'd0 || eng_busy !== 4'b0010) begin
      failures++; $display("FAIL err_spur: spur %b cnt %0d busy %b exp 1 0 0010",
                           err_spurious_done, jobs_done_cnt, eng_busy); end
    eng_done = 4'b0010;
    tick();
    eng_done = '0;
    checks++; if (jobs_done_cnt !== 16'd1 || sched_idle !== 1'b1 || err_bad_eng !== 1'b1) begin
      failures++; $display("FAIL err_sticky: cnt %0d idle %b bad %b exp 1 1 1", jobs_done_cnt, sched_idle, err_bad_eng); end
  endtask

  task automatic test_reset_midop();
    do_reset();
    drive_job(1'b1, 0, 1'b0, 'h70);           // cycle 0
    tick();
    drive_job(1'b1, 1, 1'b0, 'h71);           // cycle 1
    tick();
    drive_job(1'b1, 0, 1'b0, 'h72);           // cycle 2
    tick();
    drive_job(1'b1, 0, 1'b0, 'h73);           // cycle 3
    tick();
    drive_job(1'b1, 0, 1'b0, 'h74);           // cycle 4
    tick();                                   // cycle 5: 3 queued, 2 busy
    drive_job(1'b0, 0, 1'b0, 0);
    checks++; if (eng_busy !== 4'b0011 || sched_idle !== 1'b0) begin
      failures++; $display("FAIL mid_setup: busy %b idle %b exp 0011 0", eng_busy, sched_idle); end
    rst_n = 1'b0;
    tick();                                   // cycle 6
    rst_n = 1'b1;
    checks++; if (eng_go !== 4'b0000 || eng_busy !== 4'b0000 || eng_desc !== 128'd0) begin
      failures++; $display("FAIL mid_reset_regs: go %b busy %b desc %h exp 0000 0000 0", eng_go, eng_busy, eng_desc); end
    checks++; if ({sw_job_ready, sched_idle, err_bad_eng, err_spurious_done} !== 4'b1100 || jobs_done_cnt !== 16'd0) begin
      failures++; $display("FAIL mid_reset_flags: ready/idle/bad/spur %b cnt %0d exp 1100 0",
                           {sw_job_ready, sched_idle, err_bad_eng, err_spurious_done}, jobs_done_cnt); end
    eng_done = 4'b0011;
    tick();
    eng_done = '0;
    checks++; if (err_spurious_done !== 1'b1 || jobs_done_cnt !== 16'd0 || eng_busy !== 4'b0000) begin
      failures++; $display("FAIL mid_late_done: spur %b cnt %0d busy %b exp 1 0 0000",
                           err_spurious_done, jobs_done_cnt, eng_busy); end
    tick();
    tick();
    checks++; if (eng_go !== 4'b0000 || sched_idle !== 1'b1) begin
      failures++; $display("FAIL mid_dropped: go %b idle %b exp 0000 1", eng_go, sched_idle); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive_job(1'b0, 0, 1'b0, 0);
    eng_done = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_barrier();
    test_full();
    test_errors();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
